// File: rtl/cla_nibble_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit carry-lookahead slice (CLA4_h).
// Optional macro CLA_SEQ_SUB_EN adds a 'sub' input that turns the operation into A - B.

module CLA4_h (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci,
    output logic [3:0] S,
    output logic       Co,
    output logic       Pi
);
    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] c_s;

    // Two-level lookahead carries for one nibble
    always_comb begin
        p_s    = A ^ B;
        g_s    = A & B;
        c_s[0] = Ci;
        c_s[1] = g_s[0] | (p_s[0] & Ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & Ci);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Ci);
        S      = p_s ^ c_s[3:0];
        Co     = c_s[4];
        Pi     = &p_s;
    end
endmodule

module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] sum,
    output logic             Co,
    output logic             prop_all,
    output logic             done
`ifdef CLA_SEQ_SUB_EN
    ,
    input  logic             sub
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             acc_r;
    logic [WIDTH-1:0] psum_r;

    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic [3:0]       slice_sum_s;
    logic             slice_co_s;
    logic             slice_pi_s;
    logic [WIDTH-1:0] psum_next_s;

    // Operand B and carry as captured at the accepting edge
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            b_load_s = ~B;
            c_load_s = 1'b1;
        end else begin
            b_load_s = B;
            c_load_s = Ci;
        end
`else
        b_load_s = B;
        c_load_s = Ci;
`endif
    end

    CLA4_h u_slice (
        .A  (a_r[3:0]),
        .B  (b_r[3:0]),
        .Ci (carry_r),
        .S  (slice_sum_s),
        .Co (slice_co_s),
        .Pi (slice_pi_s)
    );

    // Sum nibbles enter at the top, so after NIB passes nibble 0 sits at the bottom
    assign psum_next_s = {slice_sum_s, psum_r[WIDTH-1:4]};

    // Sequencer FSM, datapath shift registers and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= 1'b0;
            psum_r   <= '0;
            sum      <= '0;
            Co       <= 1'b0;
            prop_all <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= b_load_s;
                        carry_r <= c_load_s;
                        cnt_r   <= '0;
                        acc_r   <= 1'b1;
                        ready   <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        ready   <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= {4'h0, a_r[WIDTH-1:4]};
                    b_r     <= {4'h0, b_r[WIDTH-1:4]};
                    psum_r  <= psum_next_s;
                    carry_r <= slice_co_s;
                    acc_r   <= acc_r & slice_pi_s;
                    cnt_r   <= cnt_r + CW'(1);
                    ready   <= 1'b0;
                    if (cnt_r == LAST_CNT) begin
                        sum      <= psum_next_s;
                        Co       <= slice_co_s;
                        prop_all <= acc_r & slice_pi_s;
                        done     <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        done     <= 1'b0;
                        state_r  <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Table-driven, scoreboarded bench for cla_nibble_seq_ctrl (WIDTH=16); honours CLA_SEQ_SUB_EN.

module tb_cla_nibble_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic [WIDTH-1:0] sum;
    logic             Co;
    logic             prop_all;
    logic             done;
    logic             sub;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] es;
        logic        eco;
        logic        ep;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        p;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[10];
    logic [15:0] last_sum;

    cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ready    (ready),
        .A        (A),
        .B        (B),
        .Ci       (Ci),
        .sum      (sum),
        .Co       (Co),
        .prop_all (prop_all),
        .done     (done)
`ifdef CLA_SEQ_SUB_EN
        ,
        .sub      (sub)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request: expected result goes into the scoreboard at the accepting edge
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input logic [15:0] es, input logic eco,
                         input logic ep, input bit repulse);
        exp_t e;
        int   early_done;
        @(negedge clk);
        check("ready_before_start", {31'd0, ready}, 32'd1);
        A = a; B = b; Ci = ci; sub = sb; start = 1'b1;
        e.s = es; e.co = eco; e.p = ep;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Ci = ~ci; sub = ~sb;
        check("ready_low_in_run", {31'd0, ready}, 32'd0);
        early_done = 0;
        for (int n = 1; n <= NIB; n++) begin
            if (repulse && n == 1) begin
                start = 1'b1; A = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (n == 1) check("sum_held_in_run", {16'd0, sum}, {16'd0, last_sum});
            if (n < NIB && done) early_done++;
        end
        start = 1'b0;
        check("done_not_early", early_done, 32'd0);
        check("done_at_edge_nib", {31'd0, done}, 32'd1);
        check("ready_low_in_done", {31'd0, ready}, 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sum", {16'd0, sum}, {16'd0, e.s});
            check("co", {31'd0, Co}, {31'd0, e.co});
            check("prop_all", {31'd0, prop_all}, {31'd0, e.p});
            last_sum = e.s;
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, ready}, 32'd1);
        check("sum_held_after", {16'd0, sum}, {16'd0, last_sum});
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_sum = 16'h0000;
        rst_n = 1'b0; start = 1'b0; A = 16'h0000; B = 16'h0000; Ci = 1'b0; sub = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_co", {31'd0, Co}, 32'd0);
        check("rst_prop", {31'd0, prop_all}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0,
                  vecs[i].es, vecs[i].eco, vecs[i].ep, 1'b0);

        // Re-pulsing start during RUN must not queue a second request
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b1);
        repeat (NIB + 2) begin
            @(negedge clk);
            check("no_queued_done", {31'd0, done}, 32'd0);
        end

        // Reset after two nibble passes discards the operation
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; Ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_co", {31'd0, Co}, 32'd0);
        check("midrst_prop", {31'd0, prop_all}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        last_sum = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NIB + 1) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
`endif

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
